// File: rtl/pipeline_register.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, stall and flush.
// Stage 0 faces the upstream side and stage DEPTH-1 drives data_o/valid_o.
module pipeline_register #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_dat [DEPTH];

  logic [DEPTH-1:0] w_acc;
  logic [DEPTH-1:0] w_src_vld;
  logic [WIDTH-1:0] w_src_dat [DEPTH];
  logic [OCC_W-1:0] w_occ;

  // Each stage takes its source from the stage behind it; stage 0 takes the input port.
  assign w_src_vld[0] = valid_i;
  assign w_src_dat[0] = data_i;

  for (genvar g = 1; g < DEPTH; g++) begin : g_src
    assign w_src_vld[g] = r_vld[g-1];
    assign w_src_dat[g] = r_dat[g-1];
  end

  // Accept chain runs from the output back to the input, so free space anywhere
  // propagates upstream in the same cycle.
  always_comb begin
    logic acc_up;
    logic mv;
    w_acc  = '0;
    acc_up = ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      mv       = r_vld[k] & acc_up;
      acc_up   = !r_vld[k] | mv;
      w_acc[k] = acc_up;
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(r_vld[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its source's pre-edge value; blocking here would shoot a beat through all stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= '0;
      // NOTE: the data stages are reset (not left X) because data_o exposes
      // the output stage directly and must read RESET_VALUE out of reset.
      for (int k = 0; k < DEPTH; k++) begin
        r_dat[k] <= RESET_VALUE;
      end
    end else if (flush_i) begin
      r_vld <= '0;
    end else if (!stall_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_acc[k]) begin
          r_vld[k] <= w_src_vld[k];
          if (w_src_vld[k]) begin
            r_dat[k] <= w_src_dat[k];
          end
        end
      end
    end
  end

  assign ready_o     = w_acc[0] & !stall_i & !flush_i & !rst_i;
  assign valid_o     = r_vld[DEPTH-1] & !stall_i & !flush_i;
  assign data_o      = r_dat[DEPTH-1];
  assign occupancy_o = w_occ;

endmodule

// File: tb/tb_pipeline_register.sv
// Directed bench for pipeline_register: a DEPTH=2 instance (a_*) and a DEPTH=3 instance (b_*)
// sharing clock and reset; expected values are hand-derived or come from a small queue model.
module tb_pipeline_register;

  localparam logic [15:0] RV = 16'hBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_stall = 0, a_flush = 0, a_valid_i = 0, a_ready_i = 0;
  logic [15:0] a_data_i = '0;
  logic        a_ready_o, a_valid_o;
  logic [15:0] a_data_o;
  logic [1:0]  a_occ;

  logic        b_stall = 0, b_flush = 0, b_valid_i = 0, b_ready_i = 0;
  logic [15:0] b_data_i = '0;
  logic        b_ready_o, b_valid_o;
  logic [15:0] b_data_o;
  logic [1:0]  b_occ;

  int n_err = 0;
  int n_chk = 0;

  logic [15:0] q[$];

  always #5 clk = ~clk;

  pipeline_register #(.WIDTH(16), .DEPTH(2), .RESET_VALUE(RV)) u_a (
    .clk_i(clk), .rst_i(rst), .stall_i(a_stall), .flush_i(a_flush),
    .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o),
    .occupancy_o(a_occ)
  );

  pipeline_register #(.WIDTH(16), .DEPTH(3), .RESET_VALUE(RV)) u_b (
    .clk_i(clk), .rst_i(rst), .stall_i(b_stall), .flush_i(b_flush),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
    .occupancy_o(b_occ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one beat into the DEPTH=2 instance while its output is blocked.
  task automatic a_fill(input logic [15:0] d);
    a_valid_i = 1; a_ready_i = 0; a_data_i = d;
    #1;
    check("a_fill_ready", a_ready_o, 1);
    tick();
    a_valid_i = 0;
  endtask

  initial begin
    // ---------------- reset ----------------
    #12;
    check("rst_a_valid", a_valid_o, 0);
    check("rst_a_ready", a_ready_o, 0);
    check("rst_a_data",  a_data_o,  RV);
    check("rst_a_occ",   a_occ,     0);
    check("rst_b_data",  b_data_o,  RV);
    #1 rst = 0;
    #1;
    check("post_rst_a_ready", a_ready_o, 1);
    check("post_rst_b_ready", b_ready_o, 1);
    tick();

    // ---------------- streaming, DEPTH=3 ----------------
    b_ready_i = 1;
    b_valid_i = 1; b_data_i = 16'h0010; #1;
    check("st0_ready", b_ready_o, 1);
    check("st0_valid", b_valid_o, 0);
    tick();
    b_data_i = 16'h0011; #1;
    check("st1_ready", b_ready_o, 1);
    check("st1_valid", b_valid_o, 0);
    tick();
    b_data_i = 16'h0012; #1;
    check("st2_valid", b_valid_o, 0);
    check("st2_occ",   b_occ,     2);
    tick();
    b_valid_i = 0; #1;
    check("st3_valid", b_valid_o, 1);
    check("st3_data",  b_data_o,  16'h0010);
    check("st3_occ",   b_occ,     3);
    tick();
    check("st4_valid", b_valid_o, 1);
    check("st4_data",  b_data_o,  16'h0011);
    tick();
    check("st5_valid", b_valid_o, 1);
    check("st5_data",  b_data_o,  16'h0012);
    tick();
    check("st6_valid", b_valid_o, 0);
    check("st6_occ",   b_occ,     0);

    // ---------------- back-pressure and bubble collapse, DEPTH=3 ----------------
    b_ready_i = 0;
    b_valid_i = 1; b_data_i = 16'h000A; #1;
    check("bp0_ready", b_ready_o, 1);
    tick();
    b_valid_i = 0; #1;
    tick();
    b_valid_i = 1; b_data_i = 16'h000B; #1;
    check("bp2_ready", b_ready_o, 1);
    tick();
    b_data_i = 16'h000C; #1;
    check("bp3_ready", b_ready_o, 1);
    check("bp3_occ",   b_occ,     2);
    tick();
    b_valid_i = 0; #1;
    check("bp_full_ready", b_ready_o, 0);
    check("bp_full_occ",   b_occ,     3);
    check("bp_full_valid", b_valid_o, 1);
    check("bp_full_data",  b_data_o,  16'h000A);
    tick();
    b_ready_i = 1; #1;
    check("bp_pass_ready", b_ready_o, 1);
    check("dr0_data", b_data_o, 16'h000A);
    tick();
    check("dr1_valid", b_valid_o, 1);
    check("dr1_data",  b_data_o,  16'h000B);
    tick();
    check("dr2_valid", b_valid_o, 1);
    check("dr2_data",  b_data_o,  16'h000C);
    tick();
    check("dr3_valid", b_valid_o, 0);

    // ---------------- full pass-through with scoreboard, DEPTH=2 ----------------
    a_fill(16'h1111); q.push_back(16'h1111);
    a_fill(16'h2222); q.push_back(16'h2222);
    #1;
    check("pt_full_ready", a_ready_o, 0);
    check("pt_full_occ",   a_occ,     2);
    for (int i = 0; i < 100; i++) begin
      a_valid_i = 1; a_ready_i = 1; a_data_i = 16'($urandom);
      #1;
      check("pt_ready", a_ready_o, 1);
      check("pt_valid", a_valid_o, 1);
      check("pt_data",  a_data_o,  q.pop_front());
      q.push_back(a_data_i);
      tick();
    end
    a_valid_i = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("pt_drain_valid", a_valid_o, 1);
      check("pt_drain_data",  a_data_o,  q.pop_front());
      tick();
    end
    check("pt_empty_valid", a_valid_o, 0);
    check("pt_empty_occ",   a_occ,     0);

    // ---------------- stall, DEPTH=2 ----------------
    a_fill(16'h0051);
    a_fill(16'h0052);
    a_stall = 1; a_valid_i = 1; a_data_i = 16'h0099; a_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", a_valid_o, 0);
      check("stall_ready", a_ready_o, 0);
      check("stall_occ",   a_occ,     2);
      check("stall_data",  a_data_o,  16'h0051);
      tick();
    end
    a_stall = 0; a_valid_i = 0; #1;
    check("unstall0_valid", a_valid_o, 1);
    check("unstall0_data",  a_data_o,  16'h0051);
    tick();
    check("unstall1_valid", a_valid_o, 1);
    check("unstall1_data",  a_data_o,  16'h0052);
    tick();
    check("unstall2_valid", a_valid_o, 0);
    check("unstall2_occ",   a_occ,     0);

    // ---------------- flush with stall and input, DEPTH=2 ----------------
    a_fill(16'h0061);
    a_fill(16'h0062);
    a_flush = 1; a_stall = 1; a_valid_i = 1; a_data_i = 16'h00FF; a_ready_i = 1; #1;
    check("flush_ready", a_ready_o, 0);
    check("flush_valid", a_valid_o, 0);
    tick();
    a_flush = 0; a_stall = 0; a_valid_i = 0; #1;
    check("post_flush_occ",   a_occ,     0);
    check("post_flush_valid", a_valid_o, 0);
    check("post_flush_data",  a_data_o,  16'h0061);
    check("post_flush_ready", a_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_leak", a_valid_o, 0);
    end

    // ---------------- asynchronous reset mid-cycle with DEPTH=2 full ----------------
    a_fill(16'h0071);
    a_fill(16'h0072);
    #1;
    check("pre_rst_occ", a_occ, 2);
    #2 rst = 1;
    #1;
    check("arst_valid", a_valid_o, 0);
    check("arst_occ",   a_occ,     0);
    check("arst_data",  a_data_o,  RV);
    check("arst_ready", a_ready_o, 0);
    #2 rst = 0;
    #1;
    check("arst_release_ready", a_ready_o, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
